// File: rtl/booth.sv
// booth -- sequential radix-2 Booth multiplier for 4-bit two's complement operands.
//
// A start request loads the accumulator, multiplier, Q(-1) bit, multiplicand and
// iteration count. Each following CALC cycle does one add/subtract step on the
// accumulator and then arithmetic-shifts {A, Q, q1} right by one. When the last
// iteration finishes, the 9-bit product {A, Q, q1} is registered and ready is raised.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-low reset
//   start    in   1  level request, accepted in IDLE or DONE
//   Q        in   4  multiplier (two's complement)
//   A        in   4  initial accumulator value (two's complement)
//   M        in   4  multiplicand (two's complement)
//   Qm       in   2  bit 0 = initial Q(-1); bit 1 ignored
//   N        in   4  iteration count, 0 selects 4 iterations
//   ready    out  1  registered, high while product is valid
//   product  out  9  registered result {A_reg, Q_reg, q1}
//
// Build option:
//   BOOTH_LIVE_PRODUCT_EN  when defined, product follows {A_reg, Q_reg, q1} after
//                          every load and CALC cycle instead of only at completion.

module booth (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] Q,
    input  logic [3:0] A,
    input  logic [3:0] M,
    input  logic [1:0] Qm,
    input  logic [3:0] N,
    output logic       ready,
    output logic [8:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] mplr_q, mplr_d;
    logic       q1_q, q1_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic [8:0] product_q, product_d;

    logic [3:0] acc_arith;
    logic [8:0] step_val;

    // Qm[1] is reserved and deliberately has no effect.
    logic       unused_qm;
    assign unused_qm = Qm[1];

    // One Booth step: add/subtract chosen by the bit pair {Q0, Q(-1)}, then an
    // arithmetic right shift of the whole {A, Q, q1} register (A sign replicated).
    // Accumulator math wraps at 4 bits.
    always_comb begin
        acc_arith = acc_q;
        case ({mplr_q[0], q1_q})
            2'b10:   acc_arith = acc_q - mcand_q;
            2'b01:   acc_arith = acc_q + mcand_q;
            default: acc_arith = acc_q;
        endcase
        step_val = {acc_arith[3], acc_arith, mplr_q};
    end

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        q1_d      = q1_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = A;
                    mplr_d  = Q;
                    q1_d    = Qm[0];
                    mcand_d = M;
                    cnt_d   = (N == 4'd0) ? 4'd4 : N;
                    ready_d = 1'b0;
                    state_d = CALC;
`ifdef BOOTH_LIVE_PRODUCT_EN
                    product_d = {A, Q, Qm[0]};
`endif
                end
            end
            CALC: begin
                acc_d  = step_val[8:5];
                mplr_d = step_val[4:1];
                q1_d   = step_val[0];
                cnt_d  = cnt_q - 4'd1;
`ifdef BOOTH_LIVE_PRODUCT_EN
                product_d = step_val;
`endif
                // cnt of 1 here means this step is the final iteration.
                if (cnt_q == 4'd1) begin
                    product_d = step_val;
                    ready_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset clears everything so an aborted run leaves no partial product behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= 4'd0;
            mplr_q    <= 4'd0;
            q1_q      <= 1'b0;
            mcand_q   <= 4'd0;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            product_q <= 9'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            q1_q      <= q1_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            product_q <= product_d;
        end
    end

    assign ready   = ready_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth.sv
// tb_booth -- directed, table-driven bench for the booth multiplier.
// Each table record holds operands plus the hand-computed 9-bit product; the
// multi-cycle cases (reset abort, held start, input churn during CALC, DONE hold)
// are written out as short sequences.

module tb_booth;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] Q;
    logic [3:0] A;
    logic [3:0] M;
    logic [1:0] Qm;
    logic [3:0] N;
    logic       ready;
    logic [8:0] product;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic [3:0] a;
        logic [3:0] m;
        logic [1:0] qm;
        logic [3:0] n;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[8];

    booth dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Q       (Q),
        .A       (A),
        .M       (M),
        .Qm      (Qm),
        .N       (N),
        .ready   (ready),
        .product (product)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a record's operands with start high across one clock edge (the load
    // edge); start is dropped afterwards unless hold is set.
    task automatic applyStimulus(input vec_t v, input bit hold);
        @(negedge clk);
        Q     = v.q;
        A     = v.a;
        M     = v.m;
        Qm    = v.qm;
        N     = v.n;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({v.name, "_load_ready"}, {8'd0, ready}, 9'd0);
        if (!hold) start = 1'b0;
    endtask

    // Count edges after the load edge until ready rises; -1 if it never does.
    task automatic waitReady(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int         cyc;
        int         iters;
        logic [8:0] prev;

        checks = 0;
        errors = 0;

        vecs[0] = '{"v029", 4'b0110, 4'b0001, 4'b1011, 2'b01, 4'd4, 9'h1BC};
        vecs[1] = '{"v030", 4'b0011, 4'b0000, 4'b0010, 2'b00, 4'd4, 9'h00C};
        vecs[2] = '{"v031", 4'b0011, 4'b0000, 4'b1110, 2'b00, 4'd0, 9'h1F4};
        vecs[3] = '{"v032", 4'b1000, 4'b0000, 4'b1000, 2'b10, 4'd4, 9'h181};
        vecs[4] = '{"n1",   4'b0011, 4'b0000, 4'b0010, 2'b00, 4'd1, 9'h1E3};
        vecs[5] = '{"n2",   4'b0011, 4'b0000, 4'b0010, 2'b00, 4'd2, 9'h1F1};
        vecs[6] = '{"n8",   4'b0000, 4'b1010, 4'b0000, 2'b00, 4'd8, 9'h1FF};
        vecs[7] = '{"neg7", 4'b1111, 4'b0000, 4'b0111, 2'b00, 4'd4, 9'h1F3};

        rst   = 1'b0;
        start = 1'b0;
        Q     = 4'd0;
        A     = 4'd0;
        M     = 4'd0;
        Qm    = 2'd0;
        N     = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {8'd0, ready}, 9'd0);
        checkOutput("reset_product", product, 9'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors: load, latency, product.
        prev = 9'd0;
        for (int k = 0; k < 8; k++) begin
            iters = (vecs[k].n == 4'd0) ? 4 : int'(vecs[k].n);
            applyStimulus(vecs[k], 1'b0);
`ifndef BOOTH_LIVE_PRODUCT_EN
            checkOutput({vecs[k].name, "_hold_prev"}, product, prev);
`endif
            waitReady(cyc);
            checkOutput({vecs[k].name, "_latency"}, 9'(cyc), 9'(iters));
            checkOutput({vecs[k].name, "_product"}, product, vecs[k].exp);
            prev = vecs[k].exp;
        end

        // DONE holds ready and product while start is low and inputs wander.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Q = 4'($urandom);
            M = 4'($urandom);
            A = 4'($urandom);
            @(posedge clk);
            #1;
            checkOutput("done_hold_ready", {8'd0, ready}, 9'd1);
            checkOutput("done_hold_product", product, 9'h1F3);
        end

        // Start held high: completes, then relaunches on the next edge.
        applyStimulus(vecs[0], 1'b1);
        waitReady(cyc);
        checkOutput("held_latency", 9'(cyc), 9'd4);
        checkOutput("held_product", product, 9'h1BC);
        @(posedge clk);
        #1;
        checkOutput("held_relaunch_ready", {8'd0, ready}, 9'd0);
        start = 1'b0;
        waitReady(cyc);
        checkOutput("held_relaunch_latency", 9'(cyc), 9'd4);
        checkOutput("held_relaunch_product", product, 9'h1BC);

        // Reset mid-CALC aborts at once; the next run is clean.
        applyStimulus(vecs[0], 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", {8'd0, ready}, 9'd0);
        checkOutput("abort_product", product, 9'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_product_stays", product, 9'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(vecs[1], 1'b0);
        waitReady(cyc);
        checkOutput("post_abort_latency", 9'(cyc), 9'd4);
        checkOutput("post_abort_product", product, 9'h00C);

        // Start toggling and input churn during CALC must not disturb the run.
        applyStimulus(vecs[2], 1'b0);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i <= 3) ? ((i % 2) == 1) : 1'b0;
            Q  = 4'($urandom);
            A  = 4'($urandom);
            M  = 4'($urandom);
            Qm = 2'($urandom);
            N  = 4'($urandom);
            @(posedge clk);
            #1;
            if (ready) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
        checkOutput("churn_latency", 9'(cyc), 9'd4);
        checkOutput("churn_product", product, 9'h1F4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
